// File: rtl/muldiv_engine_pkg.sv
// rtl/muldiv_engine_pkg.sv - op encodings and FSM states shared with the CPU control unit
package muldiv_engine_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } muldivStateT;

   function automatic logic isDivOp(input logic [1:0] opCode);
      return opCode[1];
   endfunction

   function automatic logic isSignedOp(input logic [1:0] opCode);
      return !opCode[0];
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negation for magnitudes and results
module muldiv_signfix #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         negate,
   output logic [W-1:0] result
);

   assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_engine.sv
// rtl/muldiv_engine.sv - iterative radix-2 multiply/divide engine with sign fix-up
module muldiv_engine
   import muldiv_engine_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   muldivStateT state, stateNext;
   logic [1:0]         opReg;
   logic               signA, signB, divZero;
   logic [WIDTH-1:0]   magA, magB, absA, absB;
   logic [CW-1:0]      count;
   logic [2*WIDTH:0]   acc, accStep, divShift;
   logic [WIDTH:0]     mulSum, divTrial;
   logic [2*WIDTH-1:0] prodFixed;
   logic [WIDTH-1:0]   quoFixed, remFixed;
   logic               aNeg, bNeg, startDivZero;

   assign aNeg         = isSignedOp(op) && src_a[WIDTH-1];
   assign bNeg         = isSignedOp(op) && src_b[WIDTH-1];
   assign startDivZero = isDivOp(op) && (src_b == '0);

   muldiv_signfix #(.W(WIDTH))   uAbsA (.value(src_a), .negate(aNeg), .result(absA));
   muldiv_signfix #(.W(WIDTH))   uAbsB (.value(src_b), .negate(bNeg), .result(absB));
   muldiv_signfix #(.W(2*WIDTH)) uProd (.value(acc[2*WIDTH-1:0]), .negate(signA ^ signB), .result(prodFixed));
   muldiv_signfix #(.W(WIDTH))   uQuo  (.value(acc[WIDTH-1:0]), .negate(signA ^ signB), .result(quoFixed));
   // Remainder takes the dividend's sign so division truncates toward zero.
   muldiv_signfix #(.W(WIDTH))   uRem  (.value(acc[2*WIDTH-1:WIDTH]), .negate(signA), .result(remFixed));

   always_comb begin
      mulSum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, magA} : '0);
      divShift = {acc[2*WIDTH-1:0], 1'b0};
      divTrial = divShift[2*WIDTH:WIDTH] - {1'b0, magB};
      if (isDivOp(opReg)) begin
         if (divShift[2*WIDTH:WIDTH] >= {1'b0, magB})
            accStep = {divTrial, divShift[WIDTH-1:1], 1'b1};
         else
            accStep = divShift;
      end else begin
         accStep = {mulSum, acc[WIDTH-1:0]} >> 1;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start) stateNext = startDivZero ? DONE : CALC;
         CALC:    if (abort) stateNext = IDLE;
                  else if (count == LAST_STEP) stateNext = FIX;
         FIX:     stateNext = abort ? IDLE : DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         opReg    <= OP_MULT;
         signA    <= 1'b0;
         signB    <= 1'b0;
         divZero  <= 1'b0;
         magA     <= '0;
         magB     <= '0;
         count    <= '0;
         acc      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         state    <= stateNext;
         busy     <= (stateNext != IDLE);
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: if (start) begin
               opReg   <= op;
               signA   <= aNeg;
               signB   <= bNeg;
               divZero <= startDivZero;
               magA    <= absA;
               magB    <= absB;
               count   <= '0;
               // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
               acc     <= isDivOp(op) ? {{(WIDTH+1){1'b0}}, absA} : {{(WIDTH+1){1'b0}}, absB};
            end
            CALC: if (!abort) begin
               acc   <= accStep;
               count <= count + CW'(1);
            end
            FIX: if (!abort)
               acc <= {1'b0, isDivOp(opReg) ? {remFixed, quoFixed} : prodFixed};
            DONE: begin
               done     <= 1'b1;
               div_zero <= divZero;
               if (!divZero) begin
                  hi <= acc[2*WIDTH-1:WIDTH];
                  lo <= acc[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
